// File: rtl/spi_frame_decoder.sv
// SPI frame decoder: deserializes pico_spi MSB first, decodes the first byte of a
// frame as {R/W, addr[6:0]} and later bytes as data, with a write strobe per data
// byte and an optional auto-incrementing address across a burst.
module spi_frame_decoder #(
    parameter int MAX_ADDR = 11,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic       spi_clk,
    input  logic       rstn,
    input  logic       cs,
    input  logic       pico_spi,
    output logic [6:0] addr,
    output logic       is_write,
    output logic [7:0] wdata,
    output logic       wdata_valid,
    output logic       byte_done,
    output logic       addr_err,
    output logic [7:0] frame_bytes
);

    typedef enum logic [1:0] {CMD, DATA, HALT} state_t;

    localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

    // Dropping cs or rstn clears the whole frame immediately.
    logic frst_n;
    assign frst_n = rstn & cs;

    state_t     state, state_nxt;
    logic [6:0] sr;        // only the low 7 bits are ever needed to form a byte
    logic [2:0] bit_cnt;
    logic       inc_pend;  // a data byte finished last edge; increment is due now
    logic [7:0] byte_val;
    logic       byte_end;
    logic [6:0] addr_inc;
    logic       cmd_bad;
    logic       inc_bad;
    logic       cmd_load, data_load, halt_load, do_inc;

    assign byte_val = {sr, pico_spi};
    assign byte_end = (bit_cnt == 3'd7);
    assign addr_inc = addr + 7'd1;
    assign cmd_bad  = (byte_val[6:0] == 7'd0) || (byte_val[6:0] > MAX_A);
    // 127 -> 0 wrap lands on zero, which is itself out of range
    assign inc_bad  = (addr_inc == 7'd0) || (addr_inc > MAX_A);

    // State register
    always_ff @(posedge spi_clk or negedge frst_n) begin
        if (!frst_n) state <= CMD;
        else         state <= state_nxt;
    end

    // Next-state: command decode picks DATA or HALT; an increment past the map halts
    always_comb begin
        state_nxt = state;
        case (state)
            CMD:     if (byte_end) state_nxt = cmd_bad ? HALT : DATA;
            DATA:    if (do_inc && inc_bad) state_nxt = HALT;
            default: state_nxt = HALT;
        endcase
    end

    // Per-edge actions decoded from state
    always_comb begin
        cmd_load  = (state == CMD)  && byte_end;
        data_load = (state == DATA) && byte_end;
        halt_load = (state == HALT) && byte_end;
        do_inc    = (state == DATA) && inc_pend && AUTO_INC;
    end

    // Datapath: shifter, byte counters, address/data registers and strobes
    always_ff @(posedge spi_clk or negedge frst_n) begin
        if (!frst_n) begin
            sr          <= '0;
            bit_cnt     <= '0;
            inc_pend    <= 1'b0;
            addr        <= '0;
            is_write    <= 1'b0;
            wdata       <= '0;
            wdata_valid <= 1'b0;
            byte_done   <= 1'b0;
            addr_err    <= 1'b0;
            frame_bytes <= '0;
        end else begin
            sr          <= byte_val[6:0];
            bit_cnt     <= bit_cnt + 3'd1;
            byte_done   <= byte_end;
            wdata_valid <= data_load & is_write;
            inc_pend    <= data_load;
            if (byte_end && frame_bytes != 8'hFF)
                frame_bytes <= frame_bytes + 8'd1;
            if (cmd_load) begin
                is_write <= byte_val[7];
                addr     <= byte_val[6:0];
                addr_err <= cmd_bad;
            end
            if (data_load || halt_load)
                wdata <= byte_val;
            // Increment one edge after the data byte so addr is stable during wdata_valid
            if (do_inc) begin
                addr <= addr_inc;
                if (inc_bad) addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Bench for spi_frame_decoder: two instances (AUTO_INC=1 and AUTO_INC=0) share the
// serial inputs; expected write strobes are queued per instance and popped on each
// observed wdata_valid.
module tb_spi_frame_decoder;

    logic       spi_clk = 1'b0;
    logic       rstn, cs, pico_spi;
    logic [6:0] addr0, addr1;
    logic       iw0, iw1, wv0, wv1, bd0, bd1, ae0, ae1;
    logic [7:0] wd0, wd1, fb0, fb1;

    int checks   = 0;
    int failures = 0;
    int bd_cnt   = 0;

    logic [14:0] q0[$];
    logic [14:0] q1[$];

    always #5 spi_clk = ~spi_clk;

    spi_frame_decoder #(.MAX_ADDR(11), .AUTO_INC(1'b1)) dut0 (
        .spi_clk(spi_clk), .rstn(rstn), .cs(cs), .pico_spi(pico_spi),
        .addr(addr0), .is_write(iw0), .wdata(wd0), .wdata_valid(wv0),
        .byte_done(bd0), .addr_err(ae0), .frame_bytes(fb0));

    spi_frame_decoder #(.MAX_ADDR(11), .AUTO_INC(1'b0)) dut1 (
        .spi_clk(spi_clk), .rstn(rstn), .cs(cs), .pico_spi(pico_spi),
        .addr(addr1), .is_write(iw1), .wdata(wd1), .wdata_valid(wv1),
        .byte_done(bd1), .addr_err(ae1), .frame_bytes(fb1));

    // Scoreboard consumer: every observed write strobe must match the queue head
    always @(negedge spi_clk) begin
        logic [14:0] e;
        if (wv0) begin
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid0 got addr=%0d wdata=%h, required no strobe", addr0, wd0);
            end else begin
                e = q0.pop_front();
                if ({addr0, wd0} !== e) begin
                    failures++;
                    $display("FAIL valid0 got addr=%0d wdata=%h, required addr=%0d wdata=%h",
                             addr0, wd0, e[14:8], e[7:0]);
                end
            end
        end
        if (wv1) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid1 got addr=%0d wdata=%h, required no strobe", addr1, wd1);
            end else begin
                e = q1.pop_front();
                if ({addr1, wd1} !== e) begin
                    failures++;
                    $display("FAIL valid1 got addr=%0d wdata=%h, required addr=%0d wdata=%h",
                             addr1, wd1, e[14:8], e[7:0]);
                end
            end
        end
        if (bd0) bd_cnt++;
    end

    // Shift n bits of b, MSB first; returns 1 time unit after the last sampling edge
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge spi_clk);
            pico_spi = b[7-i];
            @(posedge spi_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic push0(input logic [6:0] a, input logic [7:0] d);
        q0.push_back({a, d});
    endtask

    task automatic push1(input logic [6:0] a, input logic [7:0] d);
        q1.push_back({a, d});
    endtask

    task automatic start_frame();
        cs     = 1'b1;
        bd_cnt = 0;
    endtask

    // Drop cs, expect an immediate clear, and require all queued strobes consumed
    task automatic end_frame(input string name);
        @(negedge spi_clk);
        cs = 1'b0;
        #1;
        checks++;
        if ({addr0, iw0, wd0, wv0, bd0, ae0, fb0} !== 27'd0) begin
            failures++;
            $display("FAIL %s_cs_clear got addr=%0d iw=%b wd=%h wv=%b bd=%b ae=%b fb=%0d, required all 0",
                     name, addr0, iw0, wd0, wv0, bd0, ae0, fb0);
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_valid got pending0=%0d pending1=%0d, required 0 0",
                     name, q0.size(), q1.size());
        end
        q0.delete();
        q1.delete();
        @(posedge spi_clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; cs = 1'b0; pico_spi = 1'b0;
        repeat (3) @(posedge spi_clk);
        #1;
        checks++;
        if ({addr0, iw0, wd0, wv0, bd0, ae0, fb0} !== 27'd0) begin
            failures++;
            $display("FAIL reset got addr=%0d iw=%b wd=%h fb=%0d, required all 0", addr0, iw0, wd0, fb0);
        end
        rstn = 1'b1;
        send_bits(8'hFF, 3);  // cs low: frame held in reset, nothing shifts
        checks++;
        if ({addr0, fb0, bd0} !== 16'd0) begin
            failures++;
            $display("FAIL cs_idle got addr=%0d fb=%0d bd=%b, required 0 0 0", addr0, fb0, bd0);
        end
    endtask

    task automatic test_write();
        start_frame();
        send_byte(8'h82);
        checks++;
        if (addr0 !== 7'd2 || iw0 !== 1'b1 || fb0 !== 8'd1 || bd0 !== 1'b1 || ae0 !== 1'b0) begin
            failures++;
            $display("FAIL write_cmd got addr=%0d iw=%b fb=%0d bd=%b ae=%b, required 2 1 1 1 0",
                     addr0, iw0, fb0, bd0, ae0);
        end
        push0(7'd2, 8'hA5); push1(7'd2, 8'hA5);
        send_byte(8'hA5);
        checks++;
        if (wv0 !== 1'b1 || wd0 !== 8'hA5 || addr0 !== 7'd2 || fb0 !== 8'd2) begin
            failures++;
            $display("FAIL write_data got wv=%b wd=%h addr=%0d fb=%0d, required 1 a5 2 2", wv0, wd0, addr0, fb0);
        end
        send_bits(8'h00, 1);
        checks++;
        if (addr0 !== 7'd3 || wv0 !== 1'b0 || addr1 !== 7'd2) begin
            failures++;
            $display("FAIL write_inc got addr0=%0d wv=%b addr1=%0d, required 3 0 2", addr0, wv0, addr1);
        end
        end_frame("write");
    endtask

    task automatic test_read_burst();
        start_frame();
        send_byte(8'h05);
        checks++;
        if (addr0 !== 7'd5 || iw0 !== 1'b0) begin
            failures++;
            $display("FAIL read_cmd got addr=%0d iw=%b, required 5 0", addr0, iw0);
        end
        send_byte(8'h00);
        send_byte(8'hFF);
        checks++;
        if (addr0 !== 7'd6 || wd0 !== 8'hFF) begin
            failures++;
            $display("FAIL read_mid got addr=%0d wd=%h, required 6 ff", addr0, wd0);
        end
        send_byte(8'h5A);
        send_bits(8'h00, 1);
        checks++;
        if (addr0 !== 7'd8 || ae0 !== 1'b0 || bd_cnt !== 4 || addr1 !== 7'd5 || fb0 !== 8'd4) begin
            failures++;
            $display("FAIL read_end got addr0=%0d ae=%b bd_pulses=%0d addr1=%0d fb=%0d, required 8 0 4 5 4",
                     addr0, ae0, bd_cnt, addr1, fb0);
        end
        end_frame("read");
    endtask

    task automatic test_bad_addr(input logic [7:0] cmd);
        start_frame();
        send_byte(cmd);
        checks++;
        if (ae0 !== 1'b1 || addr0 !== cmd[6:0] || ae1 !== 1'b1) begin
            failures++;
            $display("FAIL bad_cmd_%h got ae0=%b addr=%0d ae1=%b, required 1 %0d 1", cmd, ae0, addr0, ae1, cmd[6:0]);
        end
        send_byte(8'hFF);
        send_bits(8'h00, 2);
        checks++;
        if (ae0 !== 1'b1 || addr0 !== cmd[6:0] || wd0 !== 8'hFF || fb0 !== 8'd2) begin
            failures++;
            $display("FAIL bad_halt_%h got ae=%b addr=%0d wd=%h fb=%0d, required 1 %0d ff 2",
                     cmd, ae0, addr0, wd0, fb0, cmd[6:0]);
        end
        end_frame("bad");
    endtask

    task automatic test_burst_edge();
        start_frame();
        send_byte(8'h8A);
        push0(7'd10, 8'h11); push0(7'd11, 8'h22);
        push1(7'd10, 8'h11); push1(7'd10, 8'h22); push1(7'd10, 8'h33);
        send_byte(8'h11);
        send_byte(8'h22);
        send_bits(8'h33, 1);
        checks++;
        if (addr0 !== 7'd12 || ae0 !== 1'b1) begin
            failures++;
            $display("FAIL burst_overrun got addr=%0d ae=%b, required 12 1", addr0, ae0);
        end
        send_bits(8'h33 << 1, 7);
        send_bits(8'h00, 1);
        checks++;
        if (addr0 !== 7'd12 || wd0 !== 8'h33 || addr1 !== 7'd10 || ae1 !== 1'b0 || fb0 !== 8'd4) begin
            failures++;
            $display("FAIL burst_end got addr0=%0d wd=%h addr1=%0d ae1=%b fb=%0d, required 12 33 10 0 4",
                     addr0, wd0, addr1, ae1, fb0);
        end
        end_frame("burst");
    endtask

    task automatic test_partial();
        start_frame();
        send_byte(8'h81);
        send_bits(8'hF8, 5);  // partial data byte, then cs drops
        end_frame("partial");
        start_frame();
        send_byte(8'h84);
        push0(7'd4, 8'h03); push1(7'd4, 8'h03);
        send_byte(8'h03);
        checks++;
        if (wv0 !== 1'b1 || wd0 !== 8'h03 || addr0 !== 7'd4 || fb0 !== 8'd2) begin
            failures++;
            $display("FAIL partial_new got wv=%b wd=%h addr=%0d fb=%0d, required 1 03 4 2", wv0, wd0, addr0, fb0);
        end
        end_frame("partial2");
    endtask

    task automatic test_rstn_midframe();
        start_frame();
        send_byte(8'h83);
        send_byte(8'h44);  // strobe high now; reset it away before it is sampled
        checks++;
        if (wv0 !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre got wv=%b, required 1", wv0);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({addr0, iw0, wd0, wv0, bd0, ae0, fb0} !== 27'd0) begin
            failures++;
            $display("FAIL rst_during_valid got addr=%0d wv=%b wd=%h fb=%0d, required all 0", addr0, wv0, wd0, fb0);
        end
        @(posedge spi_clk); #1;
        rstn = 1'b1;
        send_byte(8'h86);
        checks++;
        if (addr0 !== 7'd6 || iw0 !== 1'b1 || fb0 !== 8'd1) begin
            failures++;
            $display("FAIL rst_fresh_cmd got addr=%0d iw=%b fb=%0d, required 6 1 1", addr0, iw0, fb0);
        end
        push0(7'd6, 8'h77); push1(7'd6, 8'h77);
        send_byte(8'h77);
        send_bits(8'hFF, 3);
        rstn = 1'b0;
        #1;
        checks++;
        if ({addr0, wd0, fb0, ae0} !== 24'd0) begin
            failures++;
            $display("FAIL rst_mid_byte got addr=%0d wd=%h fb=%0d ae=%b, required all 0", addr0, wd0, fb0, ae0);
        end
        @(posedge spi_clk); #1;
        rstn = 1'b1;
        send_byte(8'h07);
        checks++;
        if (addr0 !== 7'd7 || iw0 !== 1'b0 || fb0 !== 8'd1) begin
            failures++;
            $display("FAIL rst_fresh_cmd2 got addr=%0d iw=%b fb=%0d, required 7 0 1", addr0, iw0, fb0);
        end
        end_frame("rstn");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_burst();
        test_bad_addr(8'h8C);
        test_bad_addr(8'h80);
        test_burst_edge();
        test_partial();
        test_rstn_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
